// File: rtl/regfilewriter_pkg.sv
// rtl/regfilewriter_pkg.sv - shared constants and instruction decode helpers for the writeback stage
//
// Purpose: datapath widths, register-file geometry, default link/PC register
//          indices, instruction format codes and the decode helpers used to
//          find the destination register of a retiring instruction.
// Ports:   none (package).
package regfilewriter_pkg;

   localparam int BIT_WIDTH    = 32;
   localparam int REG_COUNT_L2 = 4;
   localparam int REG_COUNT    = 1 << REG_COUNT_L2;

   localparam int LR_ADDR_DEFAULT = 14;
   localparam int PC_ADDR_DEFAULT = 15;

   typedef enum logic [1:0] {
      FMT_DATA   = 2'd0,
      FMT_MEMORY = 2'd1,
      FMT_BRANCH = 2'd2,
      FMT_OTHER  = 2'd3
   } fmt_e;

   // Classification uses the major opcode field in bits [27:25].
   function automatic fmt_e decode_format(input logic [BIT_WIDTH-1:0] inst);
      fmt_e f;
      f = FMT_OTHER;
      if (inst[27:26] == 2'b00)
         f = FMT_DATA;
      else if (inst[27:26] == 2'b01)
         f = FMT_MEMORY;
      else if (inst[27:25] == 3'b101)
         f = FMT_BRANCH;
      return f;
   endfunction

   // Destination register sits in bits [15:12] for every register-writing format.
   function automatic logic [REG_COUNT_L2-1:0] decode_Rd(input logic [BIT_WIDTH-1:0] inst);
      return inst[15:12];
   endfunction

endpackage

// File: rtl/regfilewriter_regfile.sv
// rtl/regfilewriter_regfile.sv - 16x32 architectural register file, one write port, two bypassed read ports
//
// Purpose: architectural register storage. Reads are combinational; the
//          PC_ADDR index always returns pc_plus8, and a read of the register
//          being written this cycle returns the incoming value.
// Ports:
//   clk, reset            clock, synchronous active-high reset (clears all entries)
//   we, waddr, wdata      write port; a write to PC_ADDR is ignored
//   pc_plus8              value returned for reads of PC_ADDR
//   raddr_a/b, rdata_a/b  combinational read ports
import regfilewriter_pkg::*;

module regfilewriter_regfile #(
   parameter int PC_ADDR = PC_ADDR_DEFAULT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    we,
   input  logic [REG_COUNT_L2-1:0] waddr,
   input  logic [BIT_WIDTH-1:0]    wdata,
   input  logic [BIT_WIDTH-1:0]    pc_plus8,
   input  logic [REG_COUNT_L2-1:0] raddr_a,
   input  logic [REG_COUNT_L2-1:0] raddr_b,
   output logic [BIT_WIDTH-1:0]    rdata_a,
   output logic [BIT_WIDTH-1:0]    rdata_b
);

   localparam logic [REG_COUNT_L2-1:0] PC_A = REG_COUNT_L2'(PC_ADDR);

   logic [BIT_WIDTH-1:0] mem_q [REG_COUNT];
   logic [BIT_WIDTH-1:0] mem_d [REG_COUNT];
   logic                 we_eff;

   assign we_eff = we && (waddr != PC_A);

   always_comb begin
      mem_d = mem_q;
      if (we_eff)
         mem_d[waddr] = wdata;
   end

   always_ff @(posedge clk) begin
      if (reset)
         mem_q <= '{default: '0};
      else
         mem_q <= mem_d;
   end

   // PC override wins over the bypass; PC_ADDR is never a write target anyway.
   always_comb begin
      rdata_a = mem_q[raddr_a];
      if (raddr_a == PC_A)
         rdata_a = pc_plus8;
      else if (we_eff && (raddr_a == waddr))
         rdata_a = wdata;

      rdata_b = mem_q[raddr_b];
      if (raddr_b == PC_A)
         rdata_b = pc_plus8;
      else if (we_eff && (raddr_b == waddr))
         rdata_b = wdata;
   end

endmodule

// File: rtl/regfilewriter.sv
// rtl/regfilewriter.sv - writeback stage: register commit, PC redirect and post-redirect squash window
//
// Purpose: retires instructions from the memory stage, commits register writes,
//          issues PC redirects to fetch, drops wrong-path retirements for
//          FLUSH_CYCLES ready cycles after a redirect, and drives forwarding.
// Optional: REGFILEWRITER_RETIRE_COUNT_EN adds output retire_count, a count of
//           non-squashed retire cycles.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   enable, memaccessor_inst        upstream valid and instruction
//   ready, regfilewriter_inst       registered valid and held instruction
//   update_pc, new_pc               redirect request and target (retire cycle)
//   update_Rd, Rd_value             register write request and value (retire cycle)
//   pc_plus8                        value read back for PC_ADDR
//   rd_addr_a/b, rd_value_a/b       decoder read ports
//   pc_write, pc_write_value        one-cycle redirect strobe and target
//   flushing                        squash window active
//   fwd_has_Rd/fwd_Rd_addr/fwd_Rd_value  registered forwarding of last commit
//   retire_count                    (optional) committed retire count
import regfilewriter_pkg::*;

module regfilewriter #(
   parameter int FLUSH_CYCLES = 3,
   parameter int LR_ADDR      = LR_ADDR_DEFAULT,
   parameter int PC_ADDR      = PC_ADDR_DEFAULT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   output logic                    ready,
   input  logic [BIT_WIDTH-1:0]    memaccessor_inst,
   output logic [BIT_WIDTH-1:0]    regfilewriter_inst,
   input  logic                    update_pc,
   input  logic [BIT_WIDTH-1:0]    new_pc,
   input  logic                    update_Rd,
   input  logic [BIT_WIDTH-1:0]    Rd_value,
   input  logic [BIT_WIDTH-1:0]    pc_plus8,
   input  logic [REG_COUNT_L2-1:0] rd_addr_a,
   input  logic [REG_COUNT_L2-1:0] rd_addr_b,
   output logic [BIT_WIDTH-1:0]    rd_value_a,
   output logic [BIT_WIDTH-1:0]    rd_value_b,
   output logic                    pc_write,
   output logic [BIT_WIDTH-1:0]    pc_write_value,
   output logic                    flushing,
   output logic                    fwd_has_Rd,
   output logic [REG_COUNT_L2-1:0] fwd_Rd_addr,
   output logic [BIT_WIDTH-1:0]    fwd_Rd_value
`ifdef REGFILEWRITER_RETIRE_COUNT_EN
   ,
   output logic [BIT_WIDTH-1:0]    retire_count
`endif
);

   localparam logic [REG_COUNT_L2-1:0] LR_A  = REG_COUNT_L2'(LR_ADDR);
   localparam logic [REG_COUNT_L2-1:0] PC_A  = REG_COUNT_L2'(PC_ADDR);
   localparam logic [2:0]              FLUSH = 3'(FLUSH_CYCLES);

   logic                    ready_q, ready_d;
   logic [BIT_WIDTH-1:0]    inst_q, inst_d;
   logic [2:0]              cnt_q, cnt_d;
   logic                    flushing_q, flushing_d;
   logic                    pc_write_q, pc_write_d;
   logic [BIT_WIDTH-1:0]    pc_write_value_q, pc_write_value_d;
   logic                    fwd_has_q, fwd_has_d;
   logic [REG_COUNT_L2-1:0] fwd_addr_q, fwd_addr_d;
   logic [BIT_WIDTH-1:0]    fwd_value_q, fwd_value_d;

   logic                    retire;
   logic                    squash;
   logic [REG_COUNT_L2-1:0] wr_addr;
   logic                    rf_we;

   // A ready cycle either retires (window closed) or is dropped (window open).
   assign retire  = ready_q && (cnt_q == 3'd0);
   assign squash  = ready_q && (cnt_q != 3'd0);
   assign wr_addr = (decode_format(inst_q) == FMT_BRANCH) ? LR_A : decode_Rd(inst_q);
   // PC-targeted writes are not commits; the PC only changes through update_pc.
   assign rf_we   = retire && update_Rd && (wr_addr != PC_A);

   always_comb begin
      ready_d          = enable;
      inst_d           = enable ? memaccessor_inst : inst_q;
      cnt_d            = cnt_q;
      pc_write_d       = 1'b0;
      pc_write_value_d = pc_write_value_q;
      fwd_has_d        = fwd_has_q;
      fwd_addr_d       = fwd_addr_q;
      fwd_value_d      = fwd_value_q;
      // Lags the counter by one cycle so flushing falls the cycle after it hits 0.
      flushing_d       = (cnt_q != 3'd0);

      if (squash)
         cnt_d = cnt_q - 3'd1;

      if (retire) begin
         if (update_pc) begin
            pc_write_d       = 1'b1;
            pc_write_value_d = new_pc;
            cnt_d            = FLUSH;
            flushing_d       = 1'b1;
         end
         fwd_has_d = rf_we;
         if (rf_we) begin
            fwd_addr_d  = wr_addr;
            fwd_value_d = Rd_value;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ready_q          <= 1'b0;
         inst_q           <= '0;
         cnt_q            <= '0;
         flushing_q       <= 1'b0;
         pc_write_q       <= 1'b0;
         pc_write_value_q <= '0;
         fwd_has_q        <= 1'b0;
         fwd_addr_q       <= '0;
         fwd_value_q      <= '0;
      end else begin
         ready_q          <= ready_d;
         inst_q           <= inst_d;
         cnt_q            <= cnt_d;
         flushing_q       <= flushing_d;
         pc_write_q       <= pc_write_d;
         pc_write_value_q <= pc_write_value_d;
         fwd_has_q        <= fwd_has_d;
         fwd_addr_q       <= fwd_addr_d;
         fwd_value_q      <= fwd_value_d;
      end
   end

`ifdef REGFILEWRITER_RETIRE_COUNT_EN
   logic [BIT_WIDTH-1:0] retire_count_q, retire_count_d;

   always_comb begin
      retire_count_d = retire_count_q;
      if (retire)
         retire_count_d = retire_count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         retire_count_q <= '0;
      else
         retire_count_q <= retire_count_d;
   end

   assign retire_count = retire_count_q;
`endif

   assign ready              = ready_q;
   assign regfilewriter_inst = inst_q;
   assign pc_write           = pc_write_q;
   assign pc_write_value     = pc_write_value_q;
   assign flushing           = flushing_q;
   assign fwd_has_Rd         = fwd_has_q;
   assign fwd_Rd_addr        = fwd_addr_q;
   assign fwd_Rd_value       = fwd_value_q;

   regfilewriter_regfile #(
      .PC_ADDR (PC_ADDR)
   ) u_regfile (
      .clk      (clk),
      .reset    (reset),
      .we       (rf_we),
      .waddr    (wr_addr),
      .wdata    (Rd_value),
      .pc_plus8 (pc_plus8),
      .raddr_a  (rd_addr_a),
      .raddr_b  (rd_addr_b),
      .rdata_a  (rd_value_a),
      .rdata_b  (rd_value_b)
   );

endmodule

// File: tb/tb_regfilewriter.sv
// tb/tb_regfilewriter.sv - directed table-driven bench for regfilewriter
module tb_regfilewriter;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        ready;
   logic [31:0] memaccessor_inst;
   logic [31:0] regfilewriter_inst;
   logic        update_pc;
   logic [31:0] new_pc;
   logic        update_Rd;
   logic [31:0] Rd_value;
   logic [31:0] pc_plus8;
   logic [3:0]  rd_addr_a;
   logic [3:0]  rd_addr_b;
   logic [31:0] rd_value_a;
   logic [31:0] rd_value_b;
   logic        pc_write;
   logic [31:0] pc_write_value;
   logic        flushing;
   logic        fwd_has_Rd;
   logic [3:0]  fwd_Rd_addr;
   logic [31:0] fwd_Rd_value;
`ifdef REGFILEWRITER_RETIRE_COUNT_EN
   logic [31:0] retire_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   regfilewriter dut (
      .clk                (clk),
      .reset              (reset),
      .enable             (enable),
      .ready              (ready),
      .memaccessor_inst   (memaccessor_inst),
      .regfilewriter_inst (regfilewriter_inst),
      .update_pc          (update_pc),
      .new_pc             (new_pc),
      .update_Rd          (update_Rd),
      .Rd_value           (Rd_value),
      .pc_plus8           (pc_plus8),
      .rd_addr_a          (rd_addr_a),
      .rd_addr_b          (rd_addr_b),
      .rd_value_a         (rd_value_a),
      .rd_value_b         (rd_value_b),
      .pc_write           (pc_write),
      .pc_write_value     (pc_write_value),
      .flushing           (flushing),
      .fwd_has_Rd         (fwd_has_Rd),
      .fwd_Rd_addr        (fwd_Rd_addr),
      .fwd_Rd_value       (fwd_Rd_value)
`ifdef REGFILEWRITER_RETIRE_COUNT_EN
      ,
      .retire_count       (retire_count)
`endif
   );

   typedef struct {
      logic [31:0] inst;
      logic        upd;
      logic [31:0] val;
      logic [3:0]  raddr;
      logic [31:0] exp_rd;
      logic        chk_fwd;
      logic        exp_has;
      logic [3:0]  exp_addr;
      logic [31:0] exp_val;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Enable cycle followed by the retire cycle; returns inside the retire cycle.
   task automatic begin_retire(input logic [31:0] inst, input logic upd_rd, input logic [31:0] val,
                               input logic upd_pc, input logic [31:0] npc);
      enable           = 1'b1;
      memaccessor_inst = inst;
      update_Rd        = 1'b0;
      update_pc        = 1'b0;
      @(posedge clk); #1;
      enable    = 1'b0;
      update_Rd = upd_rd;
      Rd_value  = val;
      update_pc = upd_pc;
      new_pc    = npc;
   endtask

   task automatic end_cycle();
      @(posedge clk); #1;
      update_Rd = 1'b0;
      update_pc = 1'b0;
   endtask

   task automatic retire(input logic [31:0] inst, input logic upd_rd, input logic [31:0] val,
                         input logic upd_pc, input logic [31:0] npc);
      begin_retire(inst, upd_rd, val, upd_pc, npc);
      end_cycle();
   endtask

   task automatic rd_a(input logic [3:0] a, output logic [31:0] v);
      rd_addr_a = a;
      #1;
      v = rd_value_a;
   endtask

   function automatic logic [31:0] dp(input logic [3:0] rd);
      return 32'hE000_0000 | ({28'd0, rd} << 12);
   endfunction

   localparam logic [31:0] BL_INST = 32'hEB00_0000;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;

      vecs[0] = '{dp(4'd3), 1'b1, 32'hDEAD_BEEF, 4'd3, 32'hDEAD_BEEF, 1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF};
      vecs[1] = '{dp(4'd7), 1'b1, 32'h0000_0001, 4'd7, 32'h0000_0001, 1'b1, 1'b1, 4'd7, 32'h0000_0001};
      vecs[2] = '{dp(4'd3), 1'b0, 32'h0000_5555, 4'd3, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'd0, 32'h0};
      vecs[3] = '{32'hE590_0000, 1'b1, 32'hA5A5_A5A5, 4'd0, 32'hA5A5_A5A5, 1'b1, 1'b1, 4'd0, 32'hA5A5_A5A5};
      vecs[4] = '{32'hEB00_3000, 1'b1, 32'h0000_1234, 4'd14, 32'h0000_1234, 1'b1, 1'b1, 4'd14, 32'h0000_1234};
      vecs[5] = '{dp(4'd15), 1'b1, 32'h0000_FFFF, 4'd15, 32'h0000_0208, 1'b0, 1'b0, 4'd0, 32'h0};

      reset = 1'b1; enable = 1'b0; memaccessor_inst = '0; update_pc = 1'b0; new_pc = '0;
      update_Rd = 1'b0; Rd_value = '0; pc_plus8 = 32'h0000_0208; rd_addr_a = 4'd1; rd_addr_b = 4'd15;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("reset_ready", {31'd0, ready}, 32'd0);
      chk("reset_inst", regfilewriter_inst, 32'd0);
      chk("reset_pc_write", {31'd0, pc_write}, 32'd0);
      chk("reset_pc_write_value", pc_write_value, 32'd0);
      chk("reset_flushing", {31'd0, flushing}, 32'd0);
      chk("reset_fwd_has", {31'd0, fwd_has_Rd}, 32'd0);
      chk("reset_r1", rd_value_a, 32'd0);
      chk("reset_pc_read", rd_value_b, 32'h0000_0208);

      for (int i = 0; i < 6; i++) begin
         begin_retire(vecs[i].inst, vecs[i].upd, vecs[i].val, 1'b0, 32'd0);
         chk($sformatf("v%0d_inst", i), regfilewriter_inst, vecs[i].inst);
         chk($sformatf("v%0d_ready", i), {31'd0, ready}, 32'd1);
         end_cycle();
         rd_a(vecs[i].raddr, v);
         chk($sformatf("v%0d_read", i), v, vecs[i].exp_rd);
         if (vecs[i].chk_fwd) begin
            chk($sformatf("v%0d_fwd_has", i), {31'd0, fwd_has_Rd}, {31'd0, vecs[i].exp_has});
            if (vecs[i].exp_has) begin
               chk($sformatf("v%0d_fwd_addr", i), {28'd0, fwd_Rd_addr}, {28'd0, vecs[i].exp_addr});
               chk($sformatf("v%0d_fwd_val", i), fwd_Rd_value, vecs[i].exp_val);
            end
         end
      end

      // Same-cycle write-through bypass.
      rd_addr_b = 4'd5;
      begin_retire(dp(4'd5), 1'b1, 32'h1234_5678, 1'b0, 32'd0);
      #1;
      chk("bypass_b", rd_value_b, 32'h1234_5678);
      end_cycle();
      chk("bypass_committed", rd_value_b, 32'h1234_5678);

      // Branch-with-link: links and redirects, then a 3-cycle squash window.
      begin_retire(BL_INST, 1'b1, 32'h44, 1'b1, 32'h100);
      end_cycle();
      chk("bl_pc_write", {31'd0, pc_write}, 32'd1);
      chk("bl_pc_value", pc_write_value, 32'h100);
      chk("bl_flushing", {31'd0, flushing}, 32'd1);
      rd_a(4'd14, v);
      chk("bl_lr", v, 32'h44);
      @(posedge clk); #1;
      chk("bl_pc_write_pulse", {31'd0, pc_write}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         retire(dp(4'd2), 1'b1, 32'h9999, 1'b1, 32'h300);
         rd_a(4'd2, v);
         chk($sformatf("squash%0d_r2", i), v, 32'd0);
         chk($sformatf("squash%0d_pc_write", i), {31'd0, pc_write}, 32'd0);
      end
      chk("squash_flush_lag", {31'd0, flushing}, 32'd1);
      retire(dp(4'd2), 1'b1, 32'h9999, 1'b0, 32'd0);
      rd_a(4'd2, v);
      chk("post_window_r2", v, 32'h9999);
      chk("post_window_flushing", {31'd0, flushing}, 32'd0);
      chk("post_window_fwd_addr", {28'd0, fwd_Rd_addr}, 32'd2);

      // Reset during the squash window.
      retire(BL_INST, 1'b1, 32'h55, 1'b1, 32'h200);
      retire(dp(4'd6), 1'b1, 32'h66, 1'b0, 32'd0);
      chk("prereset_flushing", {31'd0, flushing}, 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midreset_flushing", {31'd0, flushing}, 32'd0);
      chk("midreset_pc_write", {31'd0, pc_write}, 32'd0);
      chk("midreset_fwd_has", {31'd0, fwd_has_Rd}, 32'd0);
      chk("midreset_inst", regfilewriter_inst, 32'd0);
      rd_a(4'd14, v);
      chk("midreset_r14", v, 32'd0);
      rd_a(4'd2, v);
      chk("midreset_r2", v, 32'd0);
`ifdef REGFILEWRITER_RETIRE_COUNT_EN
      chk("midreset_retire_count", retire_count, 32'd0);
`endif
      retire(dp(4'd4), 1'b1, 32'h77, 1'b0, 32'd0);
      rd_a(4'd4, v);
      chk("after_reset_r4", v, 32'h77);
      chk("after_reset_fwd_has", {31'd0, fwd_has_Rd}, 32'd1);

      // One committed write, one redirect, three squashed, one committed.
      retire(BL_INST, 1'b0, 32'd0, 1'b1, 32'h400);
      chk("redirect2_value", pc_write_value, 32'h400);
      for (int i = 0; i < 3; i++)
         retire(dp(4'd8), 1'b1, 32'h88, 1'b0, 32'd0);
      rd_a(4'd8, v);
      chk("squash2_r8", v, 32'd0);
      retire(dp(4'd9), 1'b1, 32'h99, 1'b0, 32'd0);
      rd_a(4'd9, v);
      chk("final_r9", v, 32'h99);
`ifdef REGFILEWRITER_RETIRE_COUNT_EN
      chk("retire_count", retire_count, 32'd3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
